// File: rtl/if_stage.sv
// Instruction-fetch stage plus IF/ID register. It owns the PC and arbitrates the shared
// memory port against MEM. Branches have one delay slot. A target deferred by a busy port is held in pend.
module if_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] INT_VECTOR = 16'h0008,
  parameter logic [15:0] NOP_INSTR  = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifi_pause,
  input  logic        ifi_branch,
  input  logic [15:0] ifi_new_pc,
  input  logic        ifi_int,
  input  logic        ifi_mem_busy,
  input  logic [15:0] ifi_imem_data,
  output logic [15:0] ifo_imem_addr,
  output logic        ifo_imem_re,
  output logic [15:0] ifo_addr,
  output logic [15:0] ifo_instr,
  output logic [15:0] ifo_epc,
  output logic        ifo_redirect_pending
);

  logic [15:0] pc;
  logic [15:0] ifid_addr;
  logic [15:0] ifid_instr;
  logic        pend_valid;
  logic [15:0] pend_pc;
  logic [15:0] epc;

  assign ifo_imem_addr        = pc;
  assign ifo_imem_re          = rst & ~ifi_pause & ~ifi_mem_busy;
  assign ifo_addr             = ifid_addr;
  assign ifo_instr            = ifid_instr;
  assign ifo_epc              = epc;
  assign ifo_redirect_pending = pend_valid;

  // Priority: pause > int > branch (fetch or defer) > busy bubble > normal fetch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc         <= RESET_PC;
      ifid_addr  <= 16'h0000;
      ifid_instr <= NOP_INSTR;
      pend_valid <= 1'b0;
      pend_pc    <= 16'h0000;
      epc        <= 16'h0000;
    end else if (ifi_pause) begin
      pc <= pc;
    end else if (ifi_int) begin
      ifid_addr  <= pc;
      ifid_instr <= NOP_INSTR;
      epc        <= pend_valid ? pend_pc : pc;
      pc         <= INT_VECTOR;
      pend_valid <= 1'b0;
    end else if (ifi_branch && !ifi_mem_busy) begin
      // The delay-slot instruction at pc is fetched now; the target follows.
      ifid_addr  <= pc;
      ifid_instr <= ifi_imem_data;
      pc         <= ifi_new_pc;
    end else if (ifi_branch) begin
      // The port is busy, so the delay slot is not fetched yet. Remember the target.
      ifid_addr  <= pc;
      ifid_instr <= NOP_INSTR;
      pend_valid <= 1'b1;
      pend_pc    <= ifi_new_pc;
    end else if (ifi_mem_busy) begin
      ifid_addr  <= pc;
      ifid_instr <= NOP_INSTR;
    end else begin
      ifid_addr  <= pc;
      ifid_instr <= ifi_imem_data;
      pc         <= pend_valid ? pend_pc : pc + 16'd1;
      pend_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random traffic, checked against a reference model
// through an expected-response queue drained by an independent monitor.
module tb_if_stage;

  localparam logic [15:0] RESET_PC   = 16'h0000;
  localparam logic [15:0] INT_VECTOR = 16'h0008;
  localparam logic [15:0] NOP_INSTR  = 16'h0800;
  // {chk_comb, imem_addr, imem_re, addr, instr, epc, pend}
  localparam int W = 67;

  logic        clk;
  logic        rst;
  logic        ifi_pause;
  logic        ifi_branch;
  logic [15:0] ifi_new_pc;
  logic        ifi_int;
  logic        ifi_mem_busy;
  logic [15:0] ifi_imem_data;
  logic [15:0] ifo_imem_addr;
  logic        ifo_imem_re;
  logic [15:0] ifo_addr;
  logic [15:0] ifo_instr;
  logic [15:0] ifo_epc;
  logic        ifo_redirect_pending;

  logic [W-1:0] exp_q[$];
  int checks;
  int errors;
  bit driver_done;

  if_stage #(.RESET_PC(RESET_PC), .INT_VECTOR(INT_VECTOR), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst), .ifi_pause(ifi_pause), .ifi_branch(ifi_branch),
    .ifi_new_pc(ifi_new_pc), .ifi_int(ifi_int), .ifi_mem_busy(ifi_mem_busy),
    .ifi_imem_data(ifi_imem_data), .ifo_imem_addr(ifo_imem_addr), .ifo_imem_re(ifo_imem_re),
    .ifo_addr(ifo_addr), .ifo_instr(ifo_instr), .ifo_epc(ifo_epc),
    .ifo_redirect_pending(ifo_redirect_pending)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory contents as a fixed function of the address.
  function automatic logic [15:0] mem_f(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ 16'h5A5A;
  endfunction

  assign ifi_imem_data = mem_f(ifo_imem_addr);

  // Reference model state
  logic [15:0] m_pc, m_addr, m_instr, m_epc, m_pend_pc;
  logic        m_pend, m_known;

  // Driver: applies one cycle of inputs at the negedge, advances the model, and queues the expectation.
  task automatic step(input logic r, input logic p, input logic b, input logic [15:0] npc,
                      input logic i, input logic busy);
    logic [15:0] cur_pc;
    logic        re;
    logic        chk;
    @(negedge clk);
    rst = r; ifi_pause = p; ifi_branch = b; ifi_new_pc = npc; ifi_int = i; ifi_mem_busy = busy;
    chk    = m_known;
    cur_pc = m_pc;
    re     = r & ~p & ~busy;
    if (!r) begin
      m_pc = RESET_PC; m_addr = 16'h0000; m_instr = NOP_INSTR;
      m_pend = 1'b0; m_pend_pc = 16'h0000; m_epc = 16'h0000; m_known = 1'b1;
    end else if (p) begin
      // frozen
    end else if (i) begin
      m_addr = m_pc; m_instr = NOP_INSTR;
      m_epc = m_pend ? m_pend_pc : m_pc;
      m_pc = INT_VECTOR; m_pend = 1'b0;
    end else if (b && !busy) begin
      m_addr = m_pc; m_instr = mem_f(m_pc); m_pc = npc;
    end else if (b) begin
      m_addr = m_pc; m_instr = NOP_INSTR; m_pend = 1'b1; m_pend_pc = npc;
    end else if (busy) begin
      m_addr = m_pc; m_instr = NOP_INSTR;
    end else begin
      m_addr = m_pc; m_instr = mem_f(m_pc);
      m_pc = m_pend ? m_pend_pc : m_pc + 16'd1;
      m_pend = 1'b0;
    end
    exp_q.push_back({chk, cur_pc, re, m_addr, m_instr, m_epc, m_pend});
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  // Monitor / scoreboard: the combinational outputs are checked mid-low-phase and the IF/ID registers just after the edge.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[66]) begin
          checks++;
          if (ifo_imem_addr !== e[65:50]) begin
            errors++;
            $display("FAIL imem_addr got %h exp %h t=%0t", ifo_imem_addr, e[65:50], $time);
          end
          checks++;
          if (ifo_imem_re !== e[49]) begin
            errors++;
            $display("FAIL imem_re got %b exp %b t=%0t", ifo_imem_re, e[49], $time);
          end
        end
        @(posedge clk);
        #1;
        checks++;
        if (ifo_addr !== e[48:33]) begin
          errors++;
          $display("FAIL ifid_addr got %h exp %h t=%0t", ifo_addr, e[48:33], $time);
        end
        checks++;
        if (ifo_instr !== e[32:17]) begin
          errors++;
          $display("FAIL ifid_instr got %h exp %h t=%0t", ifo_instr, e[32:17], $time);
        end
        checks++;
        if (ifo_epc !== e[16:1]) begin
          errors++;
          $display("FAIL epc got %h exp %h t=%0t", ifo_epc, e[16:1], $time);
        end
        checks++;
        if (ifo_redirect_pending !== e[0]) begin
          errors++;
          $display("FAIL redirect_pending got %b exp %b t=%0t", ifo_redirect_pending, e[0], $time);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic p, b, i, busy, r;
    int   wait_cycles;
    checks = 0; errors = 0; driver_done = 1'b0; m_known = 1'b0;
    m_pc = 16'h0000; m_addr = 16'h0000; m_instr = 16'h0000; m_epc = 16'h0000;
    m_pend = 1'b0; m_pend_pc = 16'h0000;
    rst = 1'b0; ifi_pause = 1'b0; ifi_branch = 1'b0; ifi_new_pc = 16'h0000;
    ifi_int = 1'b0; ifi_mem_busy = 1'b0;

    // Straight-line fetch from the reset PC.
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    run(5);
    // Taken branch at pc=5 with its delay slot.
    step(1'b1, 1'b0, 1'b1, 16'h0040, 1'b0, 1'b0);
    run(2);
    // The same branch while the port is busy: the target is deferred.
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    run(5);
    step(1'b1, 1'b0, 1'b1, 16'h0040, 1'b0, 1'b1);
    run(3);
    // Two pause cycles with a branch asserted at pc=9; the branch is taken afterwards.
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    run(9);
    step(1'b1, 1'b1, 1'b1, 16'h0077, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'h0077, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h0077, 1'b0, 1'b0);
    run(2);
    // Interrupt at pc=0x21, first with no redirect pending, then with one pending to 0x40.
    step(1'b1, 1'b0, 1'b1, 16'h0021, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run(2);
    step(1'b1, 1'b0, 1'b1, 16'h0021, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h0040, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run(2);
    // PC wrap from FFFF to 0000, then reset asserted during a pause.
    step(1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    run(3);
    step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    run(2);

    // Random traffic; no branch is issued while a redirect is pending (a branch in the delay slot).
    for (int n = 0; n < 600; n++) begin
      r    = ($urandom_range(0, 99) >= 2);
      p    = ($urandom_range(0, 99) < 15);
      i    = ($urandom_range(0, 99) < 5);
      busy = ($urandom_range(0, 99) < 20);
      b    = ($urandom_range(0, 99) < 15) && !m_pend;
      step(r, p, b, 16'($urandom), i, busy);
    end

    @(negedge clk);
    driver_done = 1'b1;
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 100) begin
      @(negedge clk);
      wait_cycles++;
    end
    repeat (2) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout left %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
